// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall vectors, FSM states and PC width for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_PEND,
        ST_FLUSH
    } state_t;

    // Deepest requesting stage wins: holding a later stage must also hold everything before it.
    function automatic logic [5:0] stall_prio(input logic req_id, input logic req_ex, input logic req_mem);
        if (req_mem)
            return STALL_MEM;
        else if (req_ex)
            return STALL_EX;
        else if (req_id)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// rtl/pipe_ctrl_perf.sv - saturating stall/flush performance counters
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_any,
    input  logic        flush_any,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (stall_any && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'h1;
            if (flush_any && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'h1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with stall watchdog
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            stallreq_mem,
    input  logic            flush_req,
    input  logic [PC_W-1:0] flush_pc,
    output logic [5:0]      stall,
    output logic            flush,
    output logic [PC_W-1:0] new_pc,
    output logic            stall_timeout,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(STALL_LIMIT);

    state_t          state, next_state;
    logic [5:0]      stall_c;
    logic            latch_pc;
    logic [PC_W-1:0] pc_q;
    logic [CW-1:0]   wd_cnt, wd_next;
    logic            timeout_q;
    logic            stall_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            pc_q  <= '0;
        end else begin
            state <= next_state;
            if (latch_pc)
                pc_q <= flush_pc;
        end
    end

    always_comb begin
        next_state = state;
        stall_c    = STALL_NONE;
        latch_pc   = 1'b0;
        case (state)
            ST_RUN, ST_STALL: begin
                if (flush_req) begin
                    latch_pc = 1'b1;
                    if (stallreq_mem) begin
                        stall_c    = STALL_MEM;
                        next_state = ST_PEND;
                    end else begin
                        stall_c    = STALL_ALL;
                        next_state = ST_FLUSH;
                    end
                end else begin
                    stall_c    = stall_prio(stallreq_id, stallreq_ex, stallreq_mem);
                    next_state = (stallreq_id || stallreq_ex || stallreq_mem) ? ST_STALL : ST_RUN;
                end
            end
            // Flush waits for the bus; later flush requests are dropped so the first PC wins.
            ST_PEND: begin
                if (stallreq_mem) begin
                    stall_c = STALL_MEM;
                end else begin
                    stall_c    = STALL_ALL;
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    assign stall     = rst ? stall_c : STALL_NONE;
    assign stall_any = (stall != STALL_NONE);
    assign flush     = (state == ST_FLUSH);
    assign new_pc    = pc_q;

    assign wd_next = !stall_any ? '0 : (wd_cnt >= LIMIT_V) ? wd_cnt : wd_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next >= LIMIT_V)
                timeout_q <= 1'b1;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_any      (stall_any),
        .flush_any      (flush),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int LIMIT = 8;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id, ex, mem, fr;
    logic [31:0] fpc;
    logic [5:0]  stall;
    logic        flush, stall_timeout;
    logic [31:0] new_pc, perf_stall_cnt, perf_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    bit          m_flush_now, m_wait, m_to;
    logic [31:0] m_pc;
    int          m_consec;
    longint      m_pstall, m_pflush;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (id),
        .stallreq_ex    (ex),
        .stallreq_mem   (mem),
        .flush_req      (fr),
        .flush_pc       (fpc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_timeout  (stall_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] prio(input bit i, input bit e, input bit m);
        if (m) return 6'b011111;
        if (e) return 6'b001111;
        if (i) return 6'b000111;
        return 6'b000000;
    endfunction

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input bit r, input bit i, input bit e, input bit m, input bit f,
                        input logic [31:0] pc);
        logic [5:0] e_stall;
        bit         start_flush;
        @(negedge clk);
        rst = r; id = i; ex = e; mem = m; fr = f; fpc = pc;
        #2;
        start_flush = 1'b0;
        if (!r) begin
            m_flush_now = 0; m_wait = 0; m_to = 0;
            m_pc = 32'h0; m_consec = 0; m_pstall = 0; m_pflush = 0;
            e_stall = 6'b0;
        end else if (m_flush_now)
            e_stall = 6'b0;
        else if (m_wait)
            e_stall = m ? 6'b011111 : 6'b111111;
        else if (f) begin
            start_flush = 1'b1;
            e_stall = m ? 6'b011111 : 6'b111111;
        end else
            e_stall = prio(i, e, m);

        chk("stall",         {26'b0, stall},         {26'b0, e_stall});
        chk("flush",         {31'b0, flush},         {31'b0, m_flush_now});
        chk("new_pc",        new_pc,                 m_pc);
        chk("stall_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
        chk("perf_stall",    perf_stall_cnt,         PERF ? m_pstall[31:0] : 32'h0);
        chk("perf_flush",    perf_flush_cnt,         PERF ? m_pflush[31:0] : 32'h0);

        if (r) begin
            if (e_stall != 0) m_pstall++;
            if (m_flush_now) m_pflush++;
            m_consec = (e_stall == 0) ? 0 : ((m_consec >= LIMIT) ? LIMIT : m_consec + 1);
            if (m_consec >= LIMIT) m_to = 1;
            if (start_flush) m_pc = pc;
            m_flush_now = (m_wait && !m) || (start_flush && !m);
            m_wait      = (m_wait && m) || (start_flush && m);
        end
    endtask

    initial begin
        rst = 0; id = 0; ex = 0; mem = 0; fr = 0; fpc = 32'h0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 32'hFFFF_FFFF);
        chk("reset_stall_lit", {26'b0, stall}, 32'h0);
        step(1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0, 0);
            chk("id_stall_lit", {26'b0, stall}, 32'h07);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("id_perf_lit", perf_stall_cnt, PERF ? 32'd3 : 32'd0);

        step(1, 1, 1, 0, 0, 0);
        chk("id_ex_lit", {26'b0, stall}, 32'h0F);
        step(1, 1, 1, 1, 0, 0);
        chk("id_ex_mem_lit", {26'b0, stall}, 32'h1F);
        step(1, 0, 0, 0, 0, 0);

        step(1, 0, 0, 0, 1, 32'hBFC0_0380);
        chk("flush_req_stall_lit", {26'b0, stall}, 32'h3F);
        step(1, 1, 1, 0, 1, 32'h1111_1111);
        chk("flush_lit", {31'b0, flush}, 32'h1);
        chk("flush_pc_lit", new_pc, 32'hBFC0_0380);
        step(1, 0, 0, 0, 0, 0);
        chk("perf_flush_lit", perf_flush_cnt, PERF ? 32'd1 : 32'd0);

        step(1, 0, 0, 1, 1, 32'h1234_5678);
        step(1, 0, 0, 1, 1, 32'h0000_0000);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("pend_release_lit", {26'b0, stall}, 32'h3F);
        step(1, 0, 0, 0, 0, 0);
        chk("pend_flush_pc_lit", new_pc, 32'h1234_5678);

        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h0000_0180);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 1, 0, 0, 0);
            if (k == 8) chk("timeout_c8_lit", {31'b0, stall_timeout}, 32'h0);
            if (k == 9) chk("timeout_c9_lit", {31'b0, stall_timeout}, 32'h1);
        end
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
        chk("timeout_sticky_lit", {31'b0, stall_timeout}, 32'h1);

        step(1, 0, 0, 1, 1, 32'hDEAD_0000);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("rst_pend_stall_lit", {26'b0, stall}, 32'h0);
        chk("rst_timeout_lit", {31'b0, stall_timeout}, 32'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
        chk("no_flush_after_rst_lit", {31'b0, flush}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
